tt_um_tiny_mos6502: RTL and testbench
=====================================

# tt_um_tiny_mos6502

Tiny Tapeout top-level wrapper holding a reduced 6502-compatible CPU core (A, X, PC, N/V/Z/C flags, 16-bit address space) whose bus is multiplexed onto the 24 TT user pins. Memory lives off-chip. Every memory access is a fixed 3-clock bus cycle that external glue logic tracks by counting clocks from reset release.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous reset, active-high. Level 1 resets the core at the next rising edge. The port keeps the TT name despite its polarity.
- `ena` in 1: clock enable. At 0, all state (including the bus phase) holds.
- `ui_in` in 8: read-data bus, sampled at the end of phase P2 of a read cycle.
- `uo_out` out 8: address byte. Carries `addr[7:0]` in P0 and P2, and `addr[15:8]` in P1.
- `uio_in` in 8: unused.
- `uio_out` out 8: status or write data.
  - In P0 and P1: `{5'b0, sync, we, 1'b1}`. `sync`=1 on opcode fetch; `we`=1 on a write.
  - In P2: write data when `we`=1, otherwise `8'h00`.
- `uio_oe` out 8: constant `8'hFF`.

## Operation
- Bus cycle: P0 → P1 → P2, repeating, driven by a 2-bit phase counter that wraps from P2 to P0.
- Reset vector: after reset release, read `$FFFC` (PCL) and then `$FFFD` (PCH). Then start fetching at PC.
- Instruction subset. Each instruction costs one bus cycle per byte, plus one for the data access of abs loads/stores.
  - LDA #imm (A9)
  - LDA abs (AD)
  - LDX #imm (A2)
  - STA abs (8D)
  - ADC #imm (69)
  - SBC #imm (E9)
  - AND #imm (29)
  - ORA #imm (09)
  - EOR #imm (49)
  - TAX (AA)
  - INX (E8)
  - DEX (CA)
  - CLC (18)
  - SEC (38)
  - JMP abs (4C)
  - BEQ rel (F0)
  - BNE rel (D0)
  - NOP (EA)
- Any other opcode executes as a 1-byte NOP.
- Core state machine:
  - VEC_LO → VEC_HI → FETCH.
  - FETCH → OP1 for 2- and 3-byte instructions.
  - OP1 → OP2 for 3-byte instructions.
  - OP2 → MEM for LDA abs and STA abs.
  - The last state of each instruction returns to FETCH.
  - State advances only at the end of P2.
- Flags:
  - N/Z are updated by LDA, LDX, ADC, SBC, AND, ORA, EOR, TAX, INX and DEX.
  - C/V are updated by ADC and SBC, using binary-mode 6502 semantics. SBC computes A + ~M + C.
  - No decimal mode.
- Arithmetic:
  - 8-bit results wrap. INX of FF gives 00 with Z=1; DEX of 00 gives FF with N=1.
  - PC is 16-bit and wraps FFFF→0000.
- Branches: the target is PC_after_operand + sign_extended(offset), with no extra cycle penalty. A not-taken branch continues at PC_after_operand.
- Reset values: PC=0000, A=X=00, all flags 0, phase=P0, state=VEC_LO.
- Reset-time outputs: `uo_out`=00, `uio_out`=00, `uio_oe`=FF.
- Reset asserted mid-cycle discards the current access. The write strobe deasserts immediately.

## Timing
- First P0 is the first enabled clock after `rst_n` returns to 0.
- A read is sampled at the P2 rising edge. Its result is visible to the next bus cycle.
- Outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Instruction latency in clocks, with `ena`=1:
  - implied: 3
  - immediate or branch: 6
  - JMP: 9
  - LDA abs / STA abs: 12
- Reset to first opcode fetch P0: 6 clocks.
- `ena`=0 freezes the bus outputs at their current values.

## Structure
- Shared package `mos6502_pkg` holds:
  - opcode constants
  - state enum
  - phase enum
  - reset vector address constants `16'hFFFC` and `16'hFFFD`
- One natural sub-module, `mos6502_alu`. It is combinational and takes op, A, operand and C_in, producing result, N, Z, C and V.
- The top holds the registers, the sequencer and the pin muxing.

## Test plan
- Reset and vector fetch: hold `rst_n`=1 for 2 clocks, then release.
  - Expect `uo_out` = FC, FF, FC over the first three clocks, then FD, FF, FD.
  - Feed 00 then 80: the next fetch shows address 8000 with `uio_out[2]`=1.
- Immediate and add: program `A9 7F 69 01` at 8000. A becomes 80, N=1, V=1, C=0, Z=0.
- Store: program `A9 5A 8D 34 12`.
  - The write cycle shows `uo_out` 34, 12, 34.
  - `uio_out[1]`=1 in P0 and P1; `uio_out`=5A in P2.
- Loop: program `A2 03 CA D0 FD EA`. DEX executes 3 times, the branch is taken twice, and the NOP fetch address is 8005.
- Wrap and flags: `A2 00 CA` sets X=FF, N=1. A following `E8` sets X=00, Z=1.
- Enable and reset mid-run: drop `ena` for 5 clocks mid-P1 and check the outputs stay frozen. Assert `rst_n` during a write P2: `uio_out` goes to 00, and the vector fetch restarts.

Source files
------------

// File: rtl/mos6502_pkg.sv
// mos6502_pkg: opcodes, sequencer/phase/ALU enums and decode helpers for the tiny 6502 core
package mos6502_pkg;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_AND_IMM = 8'h29;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_EOR_IMM = 8'h49;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_SEC     = 8'h38;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_BEQ     = 8'hF0;
  localparam logic [7:0] OP_BNE     = 8'hD0;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;
  typedef enum logic [2:0] {S_VEC_LO, S_VEC_HI, S_FETCH, S_OP1, S_OP2, S_MEM} state_e;
  typedef enum logic [1:0] {P0, P1, P2} phase_e;
  typedef enum logic [2:0] {ALU_PASS, ALU_ADC, ALU_SBC, ALU_AND, ALU_ORA, ALU_EOR, ALU_INC, ALU_DEC} alu_op_e;
  function automatic logic [1:0] op_len(input logic [7:0] op);
    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_ADC_IMM, OP_SBC_IMM, OP_AND_IMM,
      OP_ORA_IMM, OP_EOR_IMM, OP_BEQ, OP_BNE: return 2'd2;
      OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction
  function automatic alu_op_e alu_op_of(input logic [7:0] op);
    case (op)
      OP_ADC_IMM: return ALU_ADC;
      OP_SBC_IMM: return ALU_SBC;
      OP_AND_IMM: return ALU_AND;
      OP_ORA_IMM: return ALU_ORA;
      OP_EOR_IMM: return ALU_EOR;
      OP_INX:     return ALU_INC;
      OP_DEX:     return ALU_DEC;
      default:    return ALU_PASS;
    endcase
  endfunction
endpackage

// File: rtl/mos6502_alu.sv
// mos6502_alu: combinational binary-mode ALU; PASS forwards the operand (loads, TAX)
module mos6502_alu
  import mos6502_pkg::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a,
  input  logic [7:0] m,
  input  logic       c_in,
  output logic [7:0] res,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v
);
  logic [7:0] mm;
  logic [8:0] sum;
  always_comb begin
    mm = (op == ALU_SBC) ? ~m : m;
    sum = {1'b0, a} + {1'b0, mm} + {8'b0, c_in};
    case (op)
      ALU_ADC, ALU_SBC: res = sum[7:0];
      ALU_AND: res = a & m;
      ALU_ORA: res = a | m;
      ALU_EOR: res = a ^ m;
      ALU_INC: res = a + 8'd1;
      ALU_DEC: res = a - 8'd1;
      default: res = m;
    endcase
    n = res[7];
    z = (res == 8'h00);
    c = sum[8];
    v = (a[7] == mm[7]) && (sum[7] != a[7]);
  end
endmodule

// File: rtl/tt_um_tiny_mos6502.sv
// tt_um_tiny_mos6502: reduced 6502 core with a 3-phase bus multiplexed onto the TT pins
module tt_um_tiny_mos6502
  import mos6502_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_e st_q, st_d;
  phase_e ph_q, ph_d;
  logic run_q, run_d;
  logic [15:0] pc_q, pc_d, pc_inc, br_pc, addr;
  logic [7:0] a_q, a_d, x_q, x_d, ir_q, ir_d, op_q, op_d, oph_q, oph_d;
  logic n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
  logic [7:0] cur, alu_a, alu_m, alu_res;
  logic alu_n, alu_z, alu_c, alu_v, we;
  alu_op_e alu_op;
  logic unused;
  assign unused = ^uio_in;
  always_comb begin
    cur = (st_q == S_FETCH) ? ui_in : ir_q;
    alu_op = alu_op_of(cur);
    alu_a = (alu_op == ALU_INC || alu_op == ALU_DEC) ? x_q : a_q;
    alu_m = (st_q == S_FETCH) ? a_q : ui_in;
    pc_inc = pc_q + 16'd1;
    br_pc = pc_inc + {{8{ui_in[7]}}, ui_in};
  end
  mos6502_alu u_alu (
    .op(alu_op), .a(alu_a), .m(alu_m), .c_in(c_q),
    .res(alu_res), .n(alu_n), .z(alu_z), .c(alu_c), .v(alu_v)
  );
  // run_q keeps the pins at 00 until the first enabled clock after reset release
  always_comb begin
    run_d = 1'b1;
    st_d = st_q;
    pc_d = pc_q;
    a_d = a_q;
    x_d = x_q;
    ir_d = ir_q;
    op_d = op_q;
    oph_d = oph_q;
    {n_d, v_d, z_d, c_d} = {n_q, v_q, z_q, c_q};
    ph_d = !run_q ? P0 : (ph_q == P0) ? P1 : (ph_q == P1) ? P2 : P0;
    if (run_q && ph_q == P2)
      case (st_q)
        S_VEC_LO: begin
          pc_d[7:0] = ui_in;
          st_d = S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_d[15:8] = ui_in;
          st_d = S_FETCH;
        end
        S_FETCH: begin
          ir_d = ui_in;
          pc_d = pc_inc;
          st_d = (op_len(ui_in) == 2'd1) ? S_FETCH : S_OP1;
          c_d = (ui_in == OP_CLC) ? 1'b0 : (ui_in == OP_SEC) ? 1'b1 : c_q;
          if (ui_in == OP_TAX || ui_in == OP_INX || ui_in == OP_DEX) {x_d, n_d, z_d} = {alu_res, alu_n, alu_z};
        end
        S_OP1: begin
          op_d = ui_in;
          pc_d = pc_inc;
          st_d = (op_len(ir_q) == 2'd3) ? S_OP2 : S_FETCH;
          if (ir_q inside {OP_LDA_IMM, OP_ADC_IMM, OP_SBC_IMM, OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM})
            {a_d, n_d, z_d} = {alu_res, alu_n, alu_z};
          if (ir_q inside {OP_ADC_IMM, OP_SBC_IMM}) {c_d, v_d} = {alu_c, alu_v};
          if (ir_q == OP_LDX_IMM) {x_d, n_d, z_d} = {alu_res, alu_n, alu_z};
          if ((ir_q == OP_BEQ && z_q) || (ir_q == OP_BNE && !z_q)) pc_d = br_pc;
        end
        S_OP2: begin
          oph_d = ui_in;
          pc_d = (ir_q == OP_JMP_ABS) ? {ui_in, op_q} : pc_inc;
          st_d = (ir_q == OP_JMP_ABS) ? S_FETCH : S_MEM;
        end
        S_MEM: begin
          st_d = S_FETCH;
          if (ir_q == OP_LDA_ABS) {a_d, n_d, z_d} = {alu_res, alu_n, alu_z};
        end
        default: st_d = S_VEC_LO;
      endcase
  end
  always_ff @(posedge clk)
    if (rst_n) begin
      run_q <= 1'b0;
      st_q <= S_VEC_LO;
      ph_q <= P0;
      pc_q <= 16'h0000;
      a_q <= 8'h00;
      x_q <= 8'h00;
      ir_q <= 8'h00;
      op_q <= 8'h00;
      oph_q <= 8'h00;
      {n_q, v_q, z_q, c_q} <= 4'b0000;
    end else if (ena) begin
      run_q <= run_d;
      st_q <= st_d;
      ph_q <= ph_d;
      pc_q <= pc_d;
      a_q <= a_d;
      x_q <= x_d;
      ir_q <= ir_d;
      op_q <= op_d;
      oph_q <= oph_d;
      {n_q, v_q, z_q, c_q} <= {n_d, v_d, z_d, c_d};
    end
  always_comb begin
    addr = (st_q == S_VEC_LO) ? VEC_LO_ADDR : (st_q == S_VEC_HI) ? VEC_HI_ADDR :
           (st_q == S_MEM) ? {oph_q, op_q} : pc_q;
    we = (st_q == S_MEM) && (ir_q == OP_STA_ABS);
    uo_out = !run_q ? 8'h00 : (ph_q == P1) ? addr[15:8] : addr[7:0];
    uio_out = !run_q ? 8'h00 : (ph_q == P2) ? (we ? a_q : 8'h00) : {5'b0, st_q == S_FETCH, we, 1'b1};
    uio_oe = 8'hFF;
  end
endmodule

// File: tb/tb_tt_um_tiny_mos6502.sv
// tb_tt_um_tiny_mos6502: table-driven programs plus hand-timed bus sequences
module tb_tt_um_tiny_mos6502;
  logic clk, rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [7:0] mem [0:65535];
  int compared = 0;
  int mismatched = 0;
  int bph = -1;
  logic [7:0] lo, hi;
  typedef struct {
    logic [63:0] prog;
    logic [7:0] ea;
    logic [7:0] ex;
    logic [3:0] nvzc;
  } vec_t;
  vec_t vt [16];

  tt_um_tiny_mos6502 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external glue: counts phases from reset release and serves reads in P2
  initial begin
    ui_in = 8'h00;
    lo = 8'h00;
    hi = 8'h00;
    forever begin
      @(posedge clk);
      if (rst_n) bph = -1;
      else if (ena) bph = (bph == -1) ? 0 : (bph + 1) % 3;
      @(negedge clk);
      if (bph == 0) lo = uo_out;
      if (bph == 1) hi = uo_out;
      if (bph == 2) ui_in = mem[{hi, lo}];
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [63:0] prog);
    for (int i = 0; i < 16; i++) mem[16'h8000 + 16'(i)] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h8000 + 16'(i)] = prog[63 - 8 * i -: 8];
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step(2);
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    ena = 1'b1;
    uio_in = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    vt[0]  = '{64'hA97F690100000000, 8'h80, 8'h00, 4'b1100};
    vt[1]  = '{64'hA9FF690100000000, 8'h00, 8'h00, 4'b0011};
    vt[2]  = '{64'h38A950E9F0000000, 8'h60, 8'h00, 4'b0000};
    vt[3]  = '{64'h18A950E9B0000000, 8'h9F, 8'h00, 4'b1100};
    vt[4]  = '{64'hA9F0293C090149FF, 8'hCE, 8'h00, 4'b1000};
    vt[5]  = '{64'hA200CA0000000000, 8'h00, 8'hFF, 4'b1000};
    vt[6]  = '{64'hA200CAE800000000, 8'h00, 8'h00, 4'b0010};
    vt[7]  = '{64'hA942AAE800000000, 8'h42, 8'h43, 4'b0000};
    vt[8]  = '{64'hA203CAD0FDEA0000, 8'h00, 8'h00, 4'b0010};
    vt[9]  = '{64'hA900F002A911A222, 8'h00, 8'h22, 4'b0000};
    vt[10] = '{64'hA901F002A9110000, 8'h11, 8'h00, 4'b0000};
    vt[11] = '{64'hA980AACA00000000, 8'h80, 8'h7F, 4'b0000};
    vt[12] = '{64'hAD05800000770000, 8'h77, 8'h00, 4'b0000};
    vt[13] = '{64'h4C0680A91100A233, 8'h00, 8'h33, 4'b0000};
    vt[14] = '{64'h38A9FF6900000000, 8'h00, 8'h00, 4'b0011};
    vt[15] = '{64'hA905FFE800000000, 8'h05, 8'h01, 4'b0000};

    // reset and vector fetch
    load(64'hEA00000000000000);
    do_reset();
    rst_n = 1'b1;
    chk("rst_uo", 16'(uo_out), 16'h00);
    chk("rst_uio", 16'(uio_out), 16'h00);
    chk("rst_oe", 16'(uio_oe), 16'hFF);
    rst_n = 1'b0;
    step(1); chk("vec_p0", 16'(uo_out), 16'hFC); chk("vec_stat", 16'(uio_out), 16'h01);
    step(1); chk("vec_p1", 16'(uo_out), 16'hFF);
    step(1); chk("vec_p2", 16'(uo_out), 16'hFC);
    step(1); chk("vech_p0", 16'(uo_out), 16'hFD);
    step(1); chk("vech_p1", 16'(uo_out), 16'hFF);
    step(1); chk("vech_p2", 16'(uo_out), 16'hFD);
    step(1); chk("fetch_lo", 16'(uo_out), 16'h00); chk("fetch_sync", 16'(uio_out), 16'h05);
    step(1); chk("fetch_hi", 16'(uo_out), 16'h80);

    // program table
    for (int i = 0; i < 16; i++) begin
      load(vt[i].prog);
      do_reset();
      step(60);
      chk($sformatf("v%0d_a", i), 16'(dut.a_q), 16'(vt[i].ea));
      chk($sformatf("v%0d_x", i), 16'(dut.x_q), 16'(vt[i].ex));
      chk($sformatf("v%0d_nvzc", i), 16'({dut.n_q, dut.v_q, dut.z_q, dut.c_q}), 16'(vt[i].nvzc));
    end

    // store cycle, then reset during its P2
    load(64'hA95A8D3412000000);
    do_reset();
    step(22); chk("st_p0_addr", 16'(uo_out), 16'h34); chk("st_p0_we", 16'(uio_out), 16'h03);
    step(1);  chk("st_p1_addr", 16'(uo_out), 16'h12); chk("st_p1_we", 16'(uio_out), 16'h03);
    step(1);  chk("st_p2_addr", 16'(uo_out), 16'h34); chk("st_p2_data", 16'(uio_out), 16'h5A);
    rst_n = 1'b1;
    step(1);  chk("st_rst_uio", 16'(uio_out), 16'h00); chk("st_rst_uo", 16'(uo_out), 16'h00);
    rst_n = 1'b0;
    step(1);  chk("st_revec", 16'(uo_out), 16'hFC);

    // loop, NOP fetch address, then enable freeze mid-P1
    load(64'hA203CAD0FDEA0000);
    do_reset();
    step(40); chk("loop_nop_lo", 16'(uo_out), 16'h05); chk("loop_nop_sync", 16'(uio_out), 16'h05);
    step(1);  chk("loop_nop_hi", 16'(uo_out), 16'h80);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("frz%0d_uo", i), 16'(uo_out), 16'h80);
      chk($sformatf("frz%0d_uio", i), 16'(uio_out), 16'h05);
    end
    ena = 1'b1;
    step(1); chk("thaw_p2", 16'(uo_out), 16'h05); chk("thaw_p2_uio", 16'(uio_out), 16'h00);
    step(1); chk("thaw_next", 16'(uo_out), 16'h06);
    chk("loop_x", 16'(dut.x_q), 16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
